// File: rtl/mixer_pkg.sv
// mixer_pkg
// Shared definitions for the time-multiplexed signal mixer:
//   state_t    - frame sequencer states (IDLE, ACCUM, FINISH)
//   CLIP_CNT_W - width of the clipped-frame counter
//   acc_width  - accumulator width that can never wrap for a given configuration
package mixer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int CLIP_CNT_W = 16;

  // Each term is at most SAMPLE_W+VOL_W bits wide. Adding n_ch of them needs
  // $clog2(n_ch) extra bits of headroom.
  function automatic int acc_width(input int n_ch, input int sample_w, input int vol_w);
    return sample_w + vol_w + $clog2(n_ch);
  endfunction

endpackage

// File: rtl/mixer_saturate.sv
// mixer_saturate
// Clamps a wide unsigned value to OUT_W bits and flags when clamping occurred.
// Ports:
//   din  in  IN_W   unsigned value to clamp
//   dout out OUT_W  min(din, 2^OUT_W-1)
//   clip out 1      high when din exceeds 2^OUT_W-1
module mixer_saturate #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             clip
);

  localparam logic [IN_W-1:0] MAX_OUT = {{(IN_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  // Compare against the largest representable output and clamp on overflow.
  always_comb begin
    clip = (din > MAX_OUT);
    dout = clip ? {OUT_W{1'b1}} : din[OUT_W-1:0];
  end

endmodule

// File: rtl/signal_mixer_seq.sv
// signal_mixer_seq
// Time-multiplexed saturating mixer. A frame strobe snapshots all channel
// samples, enables, volumes and the mix mode. One channel is then scaled and
// accumulated per clock. Finally the sum (optionally attenuated) is clamped
// to one output sample, and out_valid pulses for one cycle.
// Ports:
//   clk           in  1              system clock
//   rst           in  1              synchronous active-high reset
//   frame_strobe  in  1              start a new mix frame
//   samples       in  N_CH*SAMPLE_W  packed samples, channel i at [i*SAMPLE_W +: SAMPLE_W]
//   sample_enable in  N_CH           per-channel enable
//   volume        in  N_CH*VOL_W     packed per-channel volume
//   mix_mode      in  1              0 = saturating sum, 1 = (sum >> ATTEN_SHIFT) then saturate
//   sample_out    out SAMPLE_W       mixed sample, held until the next frame completes
//   out_valid     out 1              one-cycle pulse when sample_out updates
//   busy          out 1              high while a frame is in progress
//   overrun       out 1              one-cycle pulse for a strobe that arrived while busy
//   clip_count    out 16             number of clipped frames
// Configuration macro:
//   MIXER_CLIP_CNT_EN - when defined, clip_count counts clipped frames and
//                       saturates at all-ones. When undefined, clip_count is tied to 0.
module signal_mixer_seq
  import mixer_pkg::*;
#(
  parameter int N_CH        = 12,
  parameter int SAMPLE_W    = 8,
  parameter int VOL_W       = 4,
  parameter int VOL_SHIFT   = 3,
  parameter int ATTEN_SHIFT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_strobe,
  input  logic [N_CH*SAMPLE_W-1:0] samples,
  input  logic [N_CH-1:0]          sample_enable,
  input  logic [N_CH*VOL_W-1:0]    volume,
  input  logic                     mix_mode,
  output logic [SAMPLE_W-1:0]      sample_out,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     overrun,
  output logic [CLIP_CNT_W-1:0]    clip_count
);

  localparam int PROD_W = SAMPLE_W + VOL_W;
  localparam int ACC_W  = acc_width(N_CH, SAMPLE_W, VOL_W);
  localparam int IDX_W  = $clog2(N_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

  state_t                   state;
  logic [N_CH*SAMPLE_W-1:0] snap_samples;
  logic [N_CH-1:0]          snap_enable;
  logic [N_CH*VOL_W-1:0]    snap_volume;
  logic                     snap_mode;
  logic [IDX_W-1:0]         idx;
  logic [ACC_W-1:0]         acc;

  logic [SAMPLE_W-1:0]      cur_sample;
  logic [VOL_W-1:0]         cur_vol;
  logic [PROD_W-1:0]        product;
  logic [PROD_W-1:0]        term;
  logic [ACC_W-1:0]         acc_add;
  logic [ACC_W-1:0]         mixed;
  logic [SAMPLE_W-1:0]      sat_out;
  logic                     sat_clip;

  // Select the channel under the index and scale it by its volume.
  // A disabled channel adds nothing. The final mixed value applies the
  // attenuation shift only in mode 1.
  always_comb begin
    cur_sample = snap_samples[idx*SAMPLE_W +: SAMPLE_W];
    cur_vol    = snap_volume[idx*VOL_W +: VOL_W];
    product    = PROD_W'(cur_sample) * PROD_W'(cur_vol);
    term       = product >> VOL_SHIFT;
    acc_add    = snap_enable[idx] ? {{(ACC_W-PROD_W){1'b0}}, term} : '0;
    mixed      = snap_mode ? (acc >> ATTEN_SHIFT) : acc;
  end

  mixer_saturate #(
    .IN_W  (ACC_W),
    .OUT_W (SAMPLE_W)
  ) u_saturate (
    .din  (mixed),
    .dout (sat_out),
    .clip (sat_clip)
  );

  // Frame sequencer: snapshot on the strobe, accumulate one channel per
  // clock, then publish the clamped result. A strobe arriving in ACCUM or
  // FINISH is dropped and reported on overrun. The running frame continues
  // because only the snapshot registers are read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      snap_samples <= '0;
      snap_enable  <= '0;
      snap_volume  <= '0;
      snap_mode    <= 1'b0;
      idx          <= '0;
      acc          <= '0;
      sample_out   <= '0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_strobe) begin
            snap_samples <= samples;
            snap_enable  <= sample_enable;
            snap_volume  <= volume;
            snap_mode    <= mix_mode;
            acc          <= '0;
            idx          <= '0;
            busy         <= 1'b1;
            state        <= ACCUM;
          end
        end
        ACCUM: begin
          overrun <= frame_strobe;
          acc     <= acc + acc_add;
          if (idx == LAST_IDX) begin
            state <= FINISH;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        FINISH: begin
          overrun    <= frame_strobe;
          sample_out <= sat_out;
          out_valid  <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MIXER_CLIP_CNT_EN
  // Count frames whose result had to be clamped. The counter sticks at
  // all-ones rather than wrapping, and only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      clip_count <= '0;
    end else if (state == FINISH && sat_clip && clip_count != {CLIP_CNT_W{1'b1}}) begin
      clip_count <= clip_count + CLIP_CNT_W'(1);
    end
  end
`else
  // Without the counter the clip flag has no consumer.
  logic unused_clip;
  assign unused_clip = sat_clip;
  assign clip_count  = '0;
`endif

endmodule
